// File: rtl/dfe_pkg.sv
// Shared definitions for the DFE receive-chain filters.
//  - default widths and depths for the polyphase decimator
//  - Q1.15 constants
//  - clog2 for port/index sizing, decimation-factor clamp
package dfe_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_WIDTH_DEF = 15;
  localparam int TAPS_NUM_DEF   = 138;
  localparam int NUM_MAC_DEF    = 46;
  localparam int MAX_DECIM_DEF  = 8;
  localparam int GUARD_BITS_DEF = 8;

  // Largest positive Q1.15 value and the half-LSB used for half-up rounding.
  localparam int Q15_ONE    = 32767;
  localparam int ROUND_HALF = 1 << (FRAC_WIDTH_DEF - 1);

  // Ceiling log2, never below 1 so it can always size a port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Illegal decimation factors are pulled into 2..max_d.
  function automatic int clamp_decim(input int d, input int max_d);
    if (d < 2) return 2;
    if (d > max_d) return max_d;
    return d;
  endfunction

endpackage

// File: rtl/dfe_round_sat.sv
// Half-up rounding and saturation of a wide accumulator to the sample width.
// Ports:
//  acc  in   IN_W   signed accumulator value, FRAC_W fractional bits
//  y    out  OUT_W  rounded, clamped result
//  sat  out  1      result was clamped
module dfe_round_sat #(
  parameter int IN_W   = 40,
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 15
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  // One extra bit so adding the half-LSB can never wrap.
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(2 ** (FRAC_W - 1));
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2 ** (OUT_W - 1)));

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shr;

  assign sum = (IN_W+1)'(acc) + HALF;
  assign shr = sum >>> FRAC_W;

  always_comb begin
    sat = 1'b0;
    y   = shr[OUT_W-1:0];
    if (shr > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (shr < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/poly_decimator_prog.sv
// Programmable polyphase decimator, transposed form.
// Every accepted sample is multiplied by NUM_MAC coefficients H[c + D*j] and
// added into NUM_MAC partial sums; when the phase counter reaches 0 the head
// sum is emitted (rounded/saturated) and the bank shifts down by one.
// Ports:
//  CLK, RST        clock, synchronous active-low reset
//  EN              x_n accepted this cycle
//  bypass          y_m=x_n, valid=EN (datapath keeps running)
//  clr             datapath clear, latches dec_factor (coefficients kept)
//  dec_factor      decimation factor, clamped to 2..MAX_DECIM
//  coef_we/addr/data  coefficient write port
//  x_n             input sample, Q1.15
//  y_m, valid      decimated output and its one-cycle strobe
//  sat_flag        sticky saturation indicator
module poly_decimator_prog
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int TAPS_NUM   = TAPS_NUM_DEF,
  parameter int NUM_MAC    = NUM_MAC_DEF,
  parameter int MAX_DECIM  = MAX_DECIM_DEF,
  parameter int GUARD_BITS = GUARD_BITS_DEF,
  parameter int D_W        = clog2(MAX_DECIM + 1),
  parameter int A_W        = clog2(TAPS_NUM)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  bypass,
  input  logic                  clr,
  input  logic [D_W-1:0]        dec_factor,
  input  logic                  coef_we,
  input  logic [A_W-1:0]        coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_data,
  input  logic [DATA_WIDTH-1:0] x_n,
  output logic [DATA_WIDTH-1:0] y_m,
  output logic                  valid,
  output logic                  sat_flag
);

  localparam int ACC_W = 2 * DATA_WIDTH + GUARD_BITS;

  logic signed [DATA_WIDTH-1:0] h    [TAPS_NUM];
  logic signed [ACC_W-1:0]      acc  [NUM_MAC];
  logic signed [ACC_W-1:0]      prod [NUM_MAC];

  logic [D_W-1:0]        d_reg;
  logic [D_W-1:0]        phase;
  logic [D_W-1:0]        d_new;
  logic [DATA_WIDTH-1:0] y_reg;
  logic                  valid_r;
  logic                  sat_r;

  logic signed [DATA_WIDTH-1:0] x_s;
  logic signed [ACC_W-1:0]      out_sum;
  logic signed [DATA_WIDTH-1:0] rs_y;
  logic                         rs_sat;

  assign x_s   = $signed(x_n);
  assign d_new = D_W'(clamp_decim(int'(dec_factor), MAX_DECIM));

  // Coefficient RAM: no reset; a write lands at the edge, so a MAC in the
  // same cycle still reads the old value.
  always_ff @(posedge CLK) begin
    if (coef_we && int'(coef_addr) < TAPS_NUM)
      h[coef_addr] <= coef_data;
  end

  // Per-slice coefficient index and product; indices past the table read 0.
  for (genvar j = 0; j < NUM_MAC; j++) begin : g_mac
    int                             idx;
    logic signed [DATA_WIDTH-1:0]   coef;
    logic signed [2*DATA_WIDTH-1:0] mult;

    always_comb begin
      idx  = int'(phase) + int'(d_reg) * j;
      coef = (idx < TAPS_NUM) ? h[A_W'(idx)] : '0;
      mult = x_s * coef;
    end

    assign prod[j] = ACC_W'(mult);
  end

  assign out_sum = acc[0] + prod[0];

  dfe_round_sat #(
    .IN_W   (ACC_W),
    .OUT_W  (DATA_WIDTH),
    .FRAC_W (FRAC_WIDTH)
  ) u_round_sat (
    .acc (out_sum),
    .y   (rs_y),
    .sat (rs_sat)
  );

  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      for (int j = 0; j < NUM_MAC; j++) acc[j] <= '0;
      y_reg   <= '0;
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
      d_reg   <= d_new;
      phase   <= d_new - D_W'(1);
    end else begin
      valid_r <= 1'b0;
      if (EN) begin
        if (phase != '0) begin
          for (int j = 0; j < NUM_MAC; j++) acc[j] <= acc[j] + prod[j];
          phase <= phase - D_W'(1);
        end else begin
          // Block complete: emit head sum and shift the partial sums down.
          for (int j = 0; j < NUM_MAC - 1; j++) acc[j] <= acc[j+1] + prod[j+1];
          acc[NUM_MAC-1] <= '0;
          phase   <= d_reg - D_W'(1);
          y_reg   <= rs_y;
          valid_r <= 1'b1;
          if (rs_sat) sat_r <= 1'b1;
        end
      end
    end
  end

  assign y_m      = bypass ? x_n : y_reg;
  assign valid    = bypass ? EN : valid_r;
  assign sat_flag = sat_r;

endmodule

// File: tb/tb_poly_decimator_prog.sv
module tb_poly_decimator_prog;

  logic        CLK = 1'b0;
  logic        RST, EN, bypass, clr, coef_we;
  logic [3:0]  dec_factor;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data, x_n;
  logic [15:0] y_m;
  logic        valid, sat_flag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  poly_decimator_prog #(
    .DATA_WIDTH (16),
    .FRAC_WIDTH (15),
    .TAPS_NUM   (6),
    .NUM_MAC    (4),
    .MAX_DECIM  (8),
    .GUARD_BITS (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .bypass     (bypass),
    .clr        (clr),
    .dec_factor (dec_factor),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .x_n        (x_n),
    .y_m        (y_m),
    .valid      (valid),
    .sat_flag   (sat_flag)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle of input; checks valid and, when a new output is due, y_m.
  task automatic smp(input logic en, input logic [15:0] x, input logic ev,
                     input logic [15:0] ey, input string tag);
    EN  = en;
    x_n = x;
    tick();
    chk({tag, ".valid"}, 16'(valid), 16'(ev));
    if (ev) chk({tag, ".y"}, y_m, ey);
  endtask

  task automatic wcoef(input int a, input logic [15:0] d);
    EN        = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = d;
    tick();
    coef_we   = 1'b0;
  endtask

  // clr with EN=1 and a large sample: that sample must be dropped.
  task automatic do_clr(input int d, input string tag);
    clr        = 1'b1;
    dec_factor = 4'(d);
    EN         = 1'b1;
    x_n        = 16'h7FFF;
    tick();
    clr = 1'b0;
    EN  = 1'b0;
    chk({tag, ".clr_valid"}, 16'(valid), 16'h0000);
    chk({tag, ".clr_y"}, y_m, 16'h0000);
    chk({tag, ".clr_sat"}, 16'(sat_flag), 16'h0000);
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; bypass = 1'b0; clr = 1'b0; coef_we = 1'b0;
    dec_factor = 4'd3; coef_addr = '0; coef_data = '0; x_n = 16'h7FFF;

    // Reset held two cycles with live input
    tick(); tick();
    chk("rst.y", y_m, 16'h0000);
    chk("rst.valid", 16'(valid), 16'h0000);
    chk("rst.sat", 16'(sat_flag), 16'h0000);

    // Ramp coefficients H[k]=0x0800*(k+1), written while still in reset
    for (int k = 0; k < 6; k++) wcoef(k, 16'(16'h0800 * (k + 1)));
    RST = 1'b1;

    // Impulse with D=3: 0x0C00, 0x1800, 0x0000
    smp(1, 16'h4000, 0, 0, "imp0");
    smp(1, 16'h0000, 0, 0, "imp1");
    smp(1, 16'h0000, 1, 16'h0C00, "imp2");
    smp(1, 16'h0000, 0, 0, "imp3");
    smp(1, 16'h0000, 0, 0, "imp4");
    smp(1, 16'h0000, 1, 16'h1800, "imp5");
    smp(0, 16'h1234, 0, 0, "idle");
    chk("idle.hold", y_m, 16'h1800);
    smp(1, 16'h0000, 0, 0, "imp6");
    smp(1, 16'h0000, 0, 0, "imp7");
    smp(1, 16'h0000, 1, 16'h0000, "imp8");

    // Same impulse with EN gaps
    do_clr(3, "gap");
    smp(1, 16'h4000, 0, 0, "gap0");
    smp(0, 16'h5555, 0, 0, "gapi0");
    smp(1, 16'h0000, 0, 0, "gap1");
    smp(0, 16'h5555, 0, 0, "gapi1");
    smp(0, 16'h5555, 0, 0, "gapi2");
    smp(1, 16'h0000, 1, 16'h0C00, "gap2");
    smp(0, 16'h5555, 0, 0, "gapi3");
    smp(1, 16'h0000, 0, 0, "gap3");
    smp(0, 16'h5555, 0, 0, "gapi4");
    smp(1, 16'h0000, 0, 0, "gap4");
    smp(1, 16'h0000, 1, 16'h1800, "gap5");

    // Reconfig mid-block: D 3 -> 4, first output H[3]*0.5
    do_clr(3, "rc3");
    smp(1, 16'h7FFF, 0, 0, "rcmid");
    do_clr(4, "rc4");
    smp(1, 16'h4000, 0, 0, "rc4_0");
    smp(1, 16'h0000, 0, 0, "rc4_1");
    smp(1, 16'h0000, 0, 0, "rc4_2");
    smp(1, 16'h0000, 1, 16'h1000, "rc4_3");
    // Illegal 1 clamps to 2: first output H[1]*0.5
    do_clr(1, "rc1");
    smp(1, 16'h4000, 0, 0, "rc1_0");
    smp(1, 16'h0000, 1, 16'h0800, "rc1_1");
    // Illegal 15 clamps to 8: H[7] is beyond the table and reads 0
    do_clr(15, "rc15");
    smp(1, 16'h4000, 0, 0, "rc15_0");
    for (int i = 0; i < 6; i++) smp(1, 16'h0000, 0, 0, "rc15_mid");
    smp(1, 16'h0000, 1, 16'h0000, "rc15_7");

    // Saturation, positive then negative
    for (int k = 0; k < 6; k++) wcoef(k, 16'h7FFF);
    do_clr(2, "satp");
    smp(1, 16'h7FFF, 0, 0, "satp0");
    smp(1, 16'h7FFF, 1, 16'h7FFF, "satp1");
    chk("satp.flag", 16'(sat_flag), 16'h0001);
    smp(0, 16'h0000, 0, 0, "satp_idle");
    chk("satp.sticky", 16'(sat_flag), 16'h0001);
    do_clr(2, "satn");
    smp(1, 16'h8000, 0, 0, "satn0");
    smp(1, 16'h8000, 1, 16'h8000, "satn1");
    chk("satn.flag", 16'(sat_flag), 16'h0001);

    // Bypass plus coefficient write racing a MAC
    for (int k = 0; k < 6; k++) wcoef(k, 16'h0000);
    do_clr(2, "byp");
    bypass = 1'b1; EN = 1'b0; x_n = 16'h5555;
    #1;
    chk("byp.idle_y", y_m, 16'h5555);
    chk("byp.idle_valid", 16'(valid), 16'h0000);
    tick();
    EN = 1'b1; x_n = 16'h4000;
    coef_we = 1'b1; coef_addr = 3'd1; coef_data = 16'h4000;
    #1;
    chk("byp.a_y", y_m, 16'h4000);
    chk("byp.a_valid", 16'(valid), 16'h0001);
    tick();
    coef_we = 1'b0; x_n = 16'h4000;
    #1;
    chk("byp.b_y", y_m, 16'h4000);
    tick();
    bypass = 1'b0; EN = 1'b0;
    #1;
    chk("oldcoef.valid", 16'(valid), 16'h0001);
    chk("oldcoef.y", y_m, 16'h0000);
    tick();
    smp(1, 16'h4000, 0, 0, "newcoef0");
    smp(1, 16'h0000, 1, 16'h2000, "newcoef1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
